// File: rtl/edge_filter_pkg.sv
// edge_filter_pkg: control FSM encoding and default parameters for edge_filter
package edge_filter_pkg;
  localparam int DEF_CHANNELS     = 64;
  localparam int DEF_SYNC_STAGES  = 4;
  localparam int DEF_FILTER_WIDTH = 8;
  typedef enum logic {PRIME = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/edge_filter_sync.sv
// sync_chain: multi-bit, multi-stage synchroniser without reset
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             aclk,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] stage;
  // shift the asynchronous levels through the stages; metastability flops carry no reset
  always_ff @(posedge aclk) stage <= {stage[STAGES-2:0], d};
  assign q = stage[STAGES-1];
endmodule

// File: rtl/edge_filter.sv
// edge_filter: synchronised per-channel edge detector with sticky flags; glitch filter built in when EDGE_FILTER_DEBOUNCE_EN is defined
module edge_filter
  import edge_filter_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int FILTER_WIDTH = DEF_FILTER_WIDTH
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [CHANNELS-1:0]     din,
  input  logic [CHANNELS-1:0]     cfg_rise,
  input  logic [CHANNELS-1:0]     cfg_fall,
  input  logic [FILTER_WIDTH-1:0] cfg_filter,
  input  logic [CHANNELS-1:0]     sts_clr,
  output logic [CHANNELS-1:0]     dout,
  output logic [CHANNELS-1:0]     sts_flags,
  output logic                    sts_any
);
  localparam int PW = $clog2(SYNC_STAGES + 1);
  state_t state, state_nx;
  logic [PW-1:0] prime_cnt;
  logic prime;
  logic [CHANNELS-1:0] sync, filt, filt_d, flags_nx;

  sync_chain #(.WIDTH(CHANNELS), .STAGES(SYNC_STAGES)) u_sync (
    .aclk (aclk),
    .d    (din),
    .q    (sync)
  );

  // state register and prime counter
  always_ff @(posedge aclk)
    if (areset) begin
      state     <= PRIME;
      prime_cnt <= '0;
    end else begin
      state     <= state_nx;
      prime_cnt <= prime ? prime_cnt + 1'b1 : prime_cnt;
    end

  // leave PRIME once the synchroniser has been flushed for S+1 cycles
  always_comb state_nx = (state == PRIME && prime_cnt == PW'(SYNC_STAGES)) ? RUN : state;

  // output decode: priming forces the filter to follow the synchronised level
  always_comb prime = state == PRIME;

`ifdef EDGE_FILTER_DEBOUNCE_EN
  logic [FILTER_WIDTH-1:0] cnt [CHANNELS];
  // glitch filter: a change is accepted after cfg_filter+1 consecutive differing cycles
  always_ff @(posedge aclk)
    for (int i = 0; i < CHANNELS; i++)
      if (areset || prime) begin
        filt[i] <= sync[i] & ~areset;
        cnt[i]  <= '0;
      end else if (sync[i] == filt[i])
        cnt[i] <= '0;
      else if (cnt[i] >= cfg_filter) begin
        filt[i] <= sync[i];
        cnt[i]  <= '0;
      end else
        cnt[i] <= cnt[i] + FILTER_WIDTH'(cnt[i] != '1);
`else
  logic unused_cfg_filter;
  assign unused_cfg_filter = ^cfg_filter;
  // without the glitch filter the synchronised level is taken directly
  always_ff @(posedge aclk) filt <= areset ? '0 : sync;
`endif

  // edge detection against the previous filtered level, gated by the per-channel enables
  always_ff @(posedge aclk)
    if (areset) begin
      filt_d <= '0;
      dout   <= '0;
    end else if (prime) begin
      filt_d <= sync;
      dout   <= '0;
    end else begin
      filt_d <= filt;
      dout   <= (filt & ~filt_d & cfg_rise) | (~filt & filt_d & cfg_fall);
    end

  // a new pulse wins over a simultaneous clear
  always_comb flags_nx = (sts_flags & ~sts_clr) | dout;

  // sticky flags and a summary bit that tracks them in the same cycle
  always_ff @(posedge aclk) begin
    sts_flags <= areset ? '0 : flags_nx;
    sts_any   <= ~areset & |flags_nx;
  end
endmodule

// File: doc/edge_filter.md
EDGE_FILTER -- requirements
Module: edge_filter

Interface
REQ-001 SHALL have parameter CHANNELS, default 64, the number of independent input channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 4, the synchroniser depth S, legal range 2..8.
REQ-003 SHALL have parameter FILTER_WIDTH, default 8, the width of the glitch-filter counter and of cfg_filter.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port din, input, CHANNELS bits: asynchronous level inputs.
REQ-007 SHALL have port cfg_rise, input, CHANNELS bits: per-channel enable for rising-edge reporting.
REQ-008 SHALL have port cfg_fall, input, CHANNELS bits: per-channel enable for falling-edge reporting.
REQ-009 SHALL have port cfg_filter, input, FILTER_WIDTH bits: stability requirement N; a change is accepted after N+1 consecutive differing cycles.
REQ-010 SHALL have port sts_clr, input, CHANNELS bits: one-cycle clear strobes for the sticky flags.
REQ-011 SHALL have port dout, output, CHANNELS bits: one-cycle edge pulses.
REQ-012 SHALL have port sts_flags, output, CHANNELS bits: sticky edge flags.
REQ-013 SHALL have port sts_any, output, 1 bit: the OR-reduction of sts_flags, registered.

Function
REQ-014 SHALL synchronise each din bit through S flip-flops to produce sync.
REQ-015 SHALL keep a filtered level filt and a counter cnt per channel, with the following rules:
- sync == filt: cnt <= 0.
- sync != filt and cnt >= cfg_filter: filt <= sync, cnt <= 0.
- otherwise: cnt <= cnt + 1.
- cnt SHALL saturate and never wrap.
REQ-016 SHALL use ">=" in the REQ-015 comparison, so that lowering cfg_filter mid-count accepts the change on the next cycle.
REQ-017 SHALL register filt into filt_d each cycle.
REQ-018 SHALL register dout as (filt & ~filt_d & cfg_rise) | (~filt & filt_d & cfg_fall).
REQ-019 SHALL give a total latency from the first aclk edge sampling a new din level to the dout pulse of exactly S + cfg_filter + 2 cycles.
REQ-020 SHALL suppress a din pulse held for fewer than cfg_filter+1 synchronised cycles completely.
REQ-021 SHALL apply changes to cfg_rise/cfg_fall to the dout register on the cycle after the change.
REQ-022 SHALL update sts_flags as sts_flags <= (sts_flags & ~sts_clr) | dout; a set and a clear in the same cycle leave the flag at 1.
REQ-023 SHALL implement a control FSM with two states, PRIME and RUN.
REQ-024 SHALL, in PRIME, run a prime counter for S+1 cycles, force filt <= sync and filt_d <= sync, hold cnt at 0 and hold dout at 0, then enter RUN.
REQ-025 SHALL remain in RUN until reset.
REQ-026 SHALL apply the REQ-015 to REQ-018 filtering and edge detection only in RUN.

Reset
REQ-027 SHALL, on areset=1, set the following in the same edge:
- dout, sts_flags, sts_any, filt, filt_d and cnt to 0;
- the prime counter to 0;
- the FSM to PRIME.
REQ-028 SHALL NOT reset the synchroniser flops.
REQ-029 SHALL, on reset asserted mid-count or mid-pulse, discard the pending change, produce no pulse after release, and re-prime.
REQ-030 SHALL produce no edge pulses after reset release for a static din, whatever its value.

Configuration
REQ-031 SHALL compile the glitch filter (cnt, cfg_filter logic) in when macro EDGE_FILTER_DEBOUNCE_EN is defined.
REQ-032 SHALL, when EDGE_FILTER_DEBOUNCE_EN is undefined:
- register filt <= sync every RUN cycle;
- ignore cfg_filter;
- remove cnt;
- give a latency of S + 2.

Structure
REQ-033 SHALL place the FSM state encoding (PRIME, RUN) and the default parameter constants in package edge_filter_pkg.
REQ-034 SHALL implement the synchroniser as sub-module sync_chain, parameterised by width and stage count, without reset.

Verification
REQ-035 SHALL run every scenario below with CHANNELS=4, S=2, cfg_filter=3, cfg_rise=4'b1111 and cfg_fall=4'b0000 unless stated.
REQ-036 SHALL cover: release reset with din=4'b1111 held -> dout=0 and sts_flags=0 for 50 cycles.
REQ-037 SHALL cover: din[0] 0->1 and held -> a single dout[0] pulse exactly 7 cycles after the sampling edge, and sts_flags[0]=1 the next cycle.
REQ-038 SHALL cover: din[1] high for 3 cycles, then low -> no pulse, cnt[1] returns to 0.
REQ-039 SHALL cover: cfg_rise[2]=0, cfg_fall[2]=1, din[2] 0->1->0 with each level held 10 cycles -> exactly one pulse, 7 cycles after the falling sample.
REQ-040 SHALL cover: sts_clr[0]=1 on the same cycle as a dout[0] pulse -> sts_flags[0] stays 1; sts_clr[0]=1 a cycle later -> sts_flags[0]=0 and sts_any=0.
REQ-041 SHALL cover: areset pulse 2 cycles after the din[3] rise -> no dout[3] pulse, FSM back in PRIME, and RUN reached 3 cycles after release.
